// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_if
// Description : Bus bundle between the AES-128 key schedule generator and its
//               surroundings: key load strobe, round-key valid/ready stream,
//               status flags and the optional round-key storage read port.
//
//               key_in     [127:0]  cipher key, w0 in [127:96]
//               key_load            single-cycle expansion start strobe
//               rk_ready            consumer accepts the current round key
//               rk_valid            round_key / rk_idx are valid
//               round_key  [127:0]  current round key, same word order as key
//               rk_idx     [3:0]    index of round_key, 0..10
//               busy                expansion in progress
//               done                one-cycle pulse after key 10 is accepted
//               rk_rd_idx  [3:0]    storage read index
//               rk_rd_data [127:0]  storage read data
//
//               master : key source / round-key consumer side
//               slave  : the key expander
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expander_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    modport master (
        output key_in,
        output key_load,
        output rk_ready,
        output rk_rd_idx,
        input  rk_valid,
        input  round_key,
        input  rk_idx,
        input  busy,
        input  done,
        input  rk_rd_data
    );

    modport slave (
        input  key_in,
        input  key_load,
        input  rk_ready,
        input  rk_rd_idx,
        output rk_valid,
        output round_key,
        output rk_idx,
        output busy,
        output done,
        output rk_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander (with helpers aes_sbox, aes_rcon)
// Description : Sequential AES-128 key schedule. After a key_load strobe the
//               eleven round keys (index 0..10) are streamed one per accepted
//               valid/ready handshake. A key_load while expanding restarts
//               the schedule from the new key. done pulses for one cycle after
//               round key 10 is accepted.
//
//               Ports:
//                 clk    system clock, rising edge
//                 rst_n  asynchronous active-low reset
//                 bus    aes_key_expander_if.slave (key load, round-key
//                        stream, status, storage read port)
//
//               Optional feature macro: KEY_SCHED_STORE_EN
//                 defined   : 11 x 128 register file captures every accepted
//                             round key; rk_rd_data = entry[rk_rd_idx],
//                             0 for indices above 10.
//                 undefined : no storage, rk_rd_data tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_sbox: AES byte substitution computed arithmetically.
//   i_byte  [7:0]  input byte
//   o_byte  [7:0]  S-box output
// The multiplicative inverse is a^254 in GF(2^8) (0 maps to 0), built from an
// addition chain of squarings and multiplies, followed by the affine map.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_byte
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_a2;
    logic [7:0] w_a3;
    logic [7:0] w_a6;
    logic [7:0] w_a12;
    logic [7:0] w_a15;
    logic [7:0] w_a30;
    logic [7:0] w_a60;
    logic [7:0] w_a120;
    logic [7:0] w_a240;
    logic [7:0] w_a252;
    logic [7:0] w_inv;

    // a^254 = a^240 * a^12 * a^2
    assign w_a2   = gf_mul(i_byte, i_byte);
    assign w_a3   = gf_mul(w_a2, i_byte);
    assign w_a6   = gf_mul(w_a3, w_a3);
    assign w_a12  = gf_mul(w_a6, w_a6);
    assign w_a15  = gf_mul(w_a12, w_a3);
    assign w_a30  = gf_mul(w_a15, w_a15);
    assign w_a60  = gf_mul(w_a30, w_a30);
    assign w_a120 = gf_mul(w_a60, w_a60);
    assign w_a240 = gf_mul(w_a120, w_a120);
    assign w_a252 = gf_mul(w_a240, w_a12);
    assign w_inv  = gf_mul(w_a252, w_a2);

    // Affine transform: s ^ rotl(s,1) ^ rotl(s,2) ^ rotl(s,3) ^ rotl(s,4) ^ 0x63
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;
endmodule

// ----------------------------------------------------------------------------
// aes_rcon: round-constant lookup.
//   i_round_num [3:0]   round number, 1..10
//   o_rcon      [31:0]  round constant in bits [31:24], zeros below
// ----------------------------------------------------------------------------
module aes_rcon (
    input  wire logic [3:0]  i_round_num,
    output logic      [31:0] o_rcon
);
    logic [7:0] w_rc;

    always_comb begin
        w_rc = 8'h00;
        case (i_round_num)
            4'd1:    w_rc = 8'h01;
            4'd2:    w_rc = 8'h02;
            4'd3:    w_rc = 8'h04;
            4'd4:    w_rc = 8'h08;
            4'd5:    w_rc = 8'h10;
            4'd6:    w_rc = 8'h20;
            4'd7:    w_rc = 8'h40;
            4'd8:    w_rc = 8'h80;
            4'd9:    w_rc = 8'h1b;
            4'd10:   w_rc = 8'h36;
            default: w_rc = 8'h00;
        endcase
    end

    assign o_rcon = {w_rc, 24'h000000};
endmodule

// ----------------------------------------------------------------------------
// aes_key_expander: top level
// ----------------------------------------------------------------------------
module aes_key_expander (
    input  wire logic         clk,
    input  wire logic         rst_n,
    aes_key_expander_if.slave bus
);
    localparam logic [3:0] c_LAST_IDX = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_w;
    logic [127:0] w_w_nxt;
    logic [3:0]   r_rk_idx;
    logic [3:0]   w_rk_idx_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_handshake;
    logic [3:0]   w_rcon_round;
    logic [31:0]  w_rcon;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_round_next;

    assign w_handshake = (r_state == ST_EXPAND) && bus.rk_ready;

    // ------------------------------------------------------------------------
    // Next round key: t = SubWord(RotWord(w3)) ^ rcon, then a running XOR
    // chain across the four words. Only rounds 1..10 are ever requested from
    // the constant lookup; at index 10 the value is unused, so it is clamped.
    // ------------------------------------------------------------------------
    assign w_rcon_round = (r_rk_idx < c_LAST_IDX) ? (r_rk_idx + 4'd1) : c_LAST_IDX;

    aes_rcon u_rcon (
        .i_round_num (w_rcon_round),
        .o_rcon      (w_rcon)
    );

    assign w_rot = {r_w[23:0], r_w[31:24]};

    genvar g_i;
    generate
        for (g_i = 0; g_i < 4; g_i++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g_i +: 8]),
                .o_byte (w_sub[8*g_i +: 8])
            );
        end
    endgenerate

    assign w_t          = w_sub ^ w_rcon;
    assign w_n0         = r_w[127:96] ^ w_t;
    assign w_n1         = r_w[95:64]  ^ w_n0;
    assign w_n2         = r_w[63:32]  ^ w_n1;
    assign w_n3         = r_w[31:0]   ^ w_n2;
    assign w_round_next = {w_n0, w_n1, w_n2, w_n3};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_w      <= '0;
            r_rk_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_w      <= w_w_nxt;
            r_rk_idx <= w_rk_idx_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A key_load always wins over an advancing handshake,
    // so a restart coincident with acceptance of key 10 produces no done.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_w_nxt      = r_w;
        w_rk_idx_nxt = r_rk_idx;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.key_load) begin
                    w_state_nxt  = ST_EXPAND;
                    w_w_nxt      = bus.key_in;
                    w_rk_idx_nxt = 4'd0;
                end
            end

            ST_EXPAND: begin
                if (bus.key_load) begin
                    w_w_nxt      = bus.key_in;
                    w_rk_idx_nxt = 4'd0;
                end else if (w_handshake) begin
                    if (r_rk_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_w_nxt      = w_round_next;
                        w_rk_idx_nxt = r_rk_idx + 4'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.rk_valid  = (r_state == ST_EXPAND);
    assign bus.busy      = (r_state == ST_EXPAND);
    assign bus.done      = r_done;
    assign bus.round_key = r_w;
    assign bus.rk_idx    = r_rk_idx;

    // ------------------------------------------------------------------------
    // Optional round-key storage. Every accepted key is written, including
    // the one accepted in the same cycle as a restarting key_load.
    // ------------------------------------------------------------------------
`ifdef KEY_SCHED_STORE_EN
    logic [127:0] r_store [0:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_handshake) begin
            r_store[r_rk_idx] <= r_w;
        end
    end

    assign bus.rk_rd_data = (bus.rk_rd_idx <= c_LAST_IDX) ? r_store[bus.rk_rd_idx] : '0;
`else
    logic w_unused_rd_idx;

    assign w_unused_rd_idx = ^bus.rk_rd_idx;
    assign bus.rk_rd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expander
// Description : Self-checking bench for aes_key_expander. Expected round keys
//               come from an independent behavioural key-schedule model
//               (S-box by brute-force inverse search) and are queued when a
//               key is loaded, then popped on every observed handshake.
//               Storage checks follow KEY_SCHED_STORE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander;
    localparam logic [127:0] c_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n;

    aes_key_expander_if bus ();

    aes_key_expander dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa;
        logic [7:0] bb;
        logic [7:0] p;
        aa = a;
        bb = b;
        p  = 8'h00;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        inv = 8'h00;
        c   = 8'h63;
        for (int k = 1; k < 256; k++) begin
            if (m_mul(a, 8'(k)) == 8'h01) inv = 8'(k);
        end
        for (int i = 0; i < 8; i++) begin
            r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    function automatic logic [127:0] m_next(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] a3;
        t  = {m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0]), m_sbox(w[31:24])};
        t  = t ^ {rc, 24'h0};
        a0 = w[127:96] ^ t;
        a1 = w[95:64] ^ a0;
        a2 = w[63:32] ^ a1;
        a3 = w[31:0] ^ a2;
        return {a0, a1, a2, a3};
    endfunction

    task automatic push_expected(input logic [127:0] k);
        logic [127:0] w;
        logic [7:0]   rc;
        exp_t         e;
        w  = k;
        rc = 8'h01;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = w;
            sb_q.push_back(e);
            if (i < 10) begin
                w  = m_next(w, rc);
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b need 000", {bus.rk_valid, bus.busy, bus.done});
        end
        total++;
        if (bus.round_key !== 128'h0 || bus.rk_idx !== 4'h0) begin
            bad++;
            $display("FAIL reset_key: got key=%h idx=%0d need 0/0", bus.round_key, bus.rk_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.rk_valid, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got valid/busy=%b need 00", {bus.rk_valid, bus.busy});
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] keys [2];
        logic [127:0] l1   [2];
        logic [127:0] l10  [2];
        exp_t         e;
        int           done_cnt;
        int           done_at;
        keys[0] = 128'h0;       l1[0] = c_ZERO_RK1; l10[0] = c_ZERO_RK10;
        keys[1] = c_FIPS_KEY;   l1[1] = c_FIPS_RK1; l10[1] = c_FIPS_RK10;
        for (int v = 0; v < 2; v++) begin
            sb_q.delete();
            push_expected(keys[v]);
            bus.rk_ready = 1'b1;
            bus.key_in   = keys[v];
            bus.key_load = 1'b1;
            @(negedge clk);
            bus.key_load = 1'b0;
            done_cnt = 0;
            done_at  = 0;
            for (int cyc = 1; cyc <= 16; cyc++) begin
                if (bus.done) begin
                    done_cnt++;
                    done_at = cyc;
                    total++;
                    if (bus.busy !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_at_done: vec=%0d got busy=%b need 0", v, bus.busy);
                    end
                end
                if (bus.rk_valid && bus.rk_ready) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_key: vec=%0d got idx=%0d need no output", v, bus.rk_idx);
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.rk_idx !== e.idx || bus.round_key !== e.key) begin
                            bad++;
                            $display("FAIL vec_key: vec=%0d got idx=%0d key=%h need idx=%0d key=%h",
                                     v, bus.rk_idx, bus.round_key, e.idx, e.key);
                        end
                        if (e.idx == 4'd1) begin
                            total++;
                            if (bus.round_key !== l1[v]) begin
                                bad++;
                                $display("FAIL vec_rk1: vec=%0d got %h need %h", v, bus.round_key, l1[v]);
                            end
                        end
                        if (e.idx == 4'd10) begin
                            total++;
                            if (bus.round_key !== l10[v]) begin
                                bad++;
                                $display("FAIL vec_rk10: vec=%0d got %h need %h", v, bus.round_key, l10[v]);
                            end
                        end
                    end
                end
                @(negedge clk);
            end
            total++;
            if (done_cnt != 1 || done_at != 12) begin
                bad++;
                $display("FAIL done_timing: vec=%0d got count=%0d cycle=%0d need 1 at 12", v, done_cnt, done_at);
            end
            total++;
            if (sb_q.size() != 0) begin
                bad++;
                $display("FAIL missing_keys: vec=%0d got %0d left need 0", v, sb_q.size());
            end
        end
    endtask

    task automatic test_storage();
        exp_t e;
        sb_q.delete();
        push_expected(c_FIPS_KEY);
`ifdef KEY_SCHED_STORE_EN
        for (int i = 0; i < 16; i++) begin
            bus.rk_rd_idx = 4'(i);
            @(negedge clk);
            total++;
            if (i <= 10) begin
                e = sb_q.pop_front();
                if (bus.rk_rd_data !== e.key) begin
                    bad++;
                    $display("FAIL store_rd: idx=%0d got %h need %h", i, bus.rk_rd_data, e.key);
                end
            end else if (bus.rk_rd_data !== 128'h0) begin
                bad++;
                $display("FAIL store_oob: idx=%0d got %h need 0", i, bus.rk_rd_data);
            end
            if (i == 1 || i == 10) begin
                total++;
                if (bus.rk_rd_data !== ((i == 1) ? c_FIPS_RK1 : c_FIPS_RK10)) begin
                    bad++;
                    $display("FAIL store_lit: idx=%0d got %h", i, bus.rk_rd_data);
                end
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            bus.rk_rd_idx = 4'(i);
            @(negedge clk);
            total++;
            if (bus.rk_rd_data !== 128'h0) begin
                bad++;
                $display("FAIL nostore_rd: idx=%0d got %h need 0", i, bus.rk_rd_data);
            end
        end
`endif
        bus.rk_rd_idx = 4'd1;
    endtask

    task automatic test_stall();
        exp_t         e;
        int           done_cnt;
        int           stalls;
        int           cyc;
        logic         prev_stall;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        sb_q.delete();
        push_expected(c_FIPS_KEY);
        bus.rk_ready = 1'b1;
        bus.key_in   = c_FIPS_KEY;
        bus.key_load = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        done_cnt   = 0;
        stalls     = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_key   = '0;
        prev_idx   = '0;
        while (cyc < 120 && done_cnt == 0) begin
            if (bus.done) done_cnt++;
            if (prev_stall) begin
                total++;
                if (bus.round_key !== prev_key || bus.rk_idx !== prev_idx || bus.rk_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: got idx=%0d key=%h need idx=%0d key=%h",
                             bus.rk_idx, bus.round_key, prev_idx, prev_key);
                end
            end
            if (bus.rk_valid && bus.rk_idx == 4'd4 && stalls < 3) begin
                bus.rk_ready = 1'b0;
                stalls++;
            end else begin
                bus.rk_ready = 1'($urandom_range(0, 1));
            end
            prev_stall = bus.rk_valid && !bus.rk_ready;
            prev_key   = bus.round_key;
            prev_idx   = bus.rk_idx;
            if (bus.rk_valid && bus.rk_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL stall_extra: got idx=%0d need no output", bus.rk_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.rk_idx !== e.idx || bus.round_key !== e.key) begin
                        bad++;
                        $display("FAIL stall_key: got idx=%0d key=%h need idx=%0d key=%h",
                                 bus.rk_idx, bus.round_key, e.idx, e.key);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done_cnt != 1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL stall_end: got done=%0d left=%0d need 1/0", done_cnt, sb_q.size());
        end
        bus.rk_ready = 1'b1;
    endtask

    task automatic test_restart();
        exp_t e;
        int   done_cnt;
        int   cyc;
        logic restarted;
        logic check_zero;
        sb_q.delete();
        push_expected(c_FIPS_KEY);
        bus.rk_ready = 1'b1;
        bus.key_in   = c_FIPS_KEY;
        bus.key_load = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        done_cnt   = 0;
        cyc        = 0;
        restarted  = 1'b0;
        check_zero = 1'b0;
        while (cyc < 40 && !(restarted && done_cnt > 0)) begin
            if (bus.done) done_cnt++;
            if (check_zero) begin
                check_zero = 1'b0;
                total++;
                if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd0 || bus.round_key !== 128'h0) begin
                    bad++;
                    $display("FAIL restart_first: got v=%b idx=%0d key=%h need 1/0/0",
                             bus.rk_valid, bus.rk_idx, bus.round_key);
                end
            end
            if (bus.rk_valid && bus.rk_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL restart_extra: got idx=%0d need no output", bus.rk_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.rk_idx !== e.idx || bus.round_key !== e.key) begin
                        bad++;
                        $display("FAIL restart_key: got idx=%0d key=%h need idx=%0d key=%h",
                                 bus.rk_idx, bus.round_key, e.idx, e.key);
                    end
                end
                if (!restarted && bus.rk_idx == 4'd5) begin
                    restarted    = 1'b1;
                    check_zero   = 1'b1;
                    bus.key_in   = 128'h0;
                    bus.key_load = 1'b1;
                    sb_q.delete();
                    push_expected(128'h0);
                end
            end
            @(negedge clk);
            bus.key_load = 1'b0;
            cyc++;
        end
        repeat (2) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        total++;
        if (done_cnt != 1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL restart_done: got done=%0d left=%0d need 1/0", done_cnt, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int errs;
        bus.rk_ready  = 1'b1;
        bus.rk_rd_idx = 4'd1;
        bus.key_in    = c_FIPS_KEY;
        bus.key_load  = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        cyc = 0;
        while (cyc < 20 && bus.rk_idx != 4'd7) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (bus.rk_idx != 4'd7) begin
            bad++;
            $display("FAIL mid_reach7: got idx=%0d need 7", bus.rk_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000 || bus.round_key !== 128'h0
            || bus.rk_idx !== 4'h0 || bus.rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL async_reset: got v/b/d=%b idx=%0d key=%h rd=%h need all 0",
                     {bus.rk_valid, bus.busy, bus.done}, bus.rk_idx, bus.round_key, bus.rk_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        repeat (5) begin
            @(negedge clk);
            if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_after_mid_reset: got %0d active cycles need 0", errs);
        end
        bus.key_in   = 128'h0;
        bus.key_load = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        total++;
        if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd0 || bus.round_key !== 128'h0) begin
            bad++;
            $display("FAIL reload_after_reset: got v=%b idx=%0d key=%h need 1/0/0",
                     bus.rk_valid, bus.rk_idx, bus.round_key);
        end
        repeat (13) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.key_in    = '0;
        bus.key_load  = 1'b0;
        bus.rk_ready  = 1'b0;
        bus.rk_rd_idx = 4'd0;
        test_reset();
        test_known_vectors();
        test_storage();
        test_stall();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
